alu_sequencer: RTL and testbench

- Multi-cycle controller that sequences one ALU instruction byte through operand read, execute and writeback.
- Decodes the CREG field to source and destination registers, reads operands from the register file, drives the ALU and writes the result back.
- Sits between instruction fetch (valid/ready byte stream), the register file (1-cycle synchronous read, 1 write port) and the combinational/multi-cycle ALU.

---
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/alu_sequencer.sv | 80 ++++++++
 tb/tb_alu_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: fetch, register-file and ALU signals seen by the sequencer
interface alu_sequencer_if #(
  parameter int DW = 8,
  parameter int CNT_W = 16
);
  logic [7:0] insr;
  logic insr_valid;
  logic insr_ready;
  logic rf_re;
  logic [3:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic rf_we;
  logic [3:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0] alu_op;
  logic alu_start;
  logic alu_done;
  logic [DW-1:0] alu_result;
  logic busy;
  logic [CNT_W-1:0] retired;
  modport master (
    input insr, insr_valid, rf_rdata, alu_done, alu_result,
    output insr_ready, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata,
    output alu_a, alu_b, alu_op, alu_start, busy, retired
  );
  modport slave (
    output insr, insr_valid, rf_rdata, alu_done, alu_result,
    input insr_ready, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata,
    input alu_a, alu_b, alu_op, alu_start, busy, retired
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one ALU instruction byte through operand reads, execute and writeback
module alu_sequencer #(
  parameter int DW = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  alu_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;
  localparam logic [3:0] REG_A = 4'h0;
  localparam logic [3:0] REG_Y = 4'h2;
  localparam logic [3:0] REG_D = 4'h3;
  state_t state, nxt;
  logic first, take, accept;
  logic [2:0] creg;
  logic [3:0] dst, src_a, src_b;
  logic [3:0] op, dest, src_b_r, raddr, waddr;
  logic [DW-1:0] opa, opb, res;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    creg = bus.insr[6:4];
    dst = creg[2] ? REG_D : REG_A;
    src_a = (creg[1:0] == 2'd0) ? (creg[2] ? REG_A : 4'h1) : {2'b00, creg[1:0]};
    src_b = creg[2] ? REG_D : ((creg[1:0] == 2'd0) ? REG_Y : REG_A);
  end
  always_comb begin
    take = bus.insr_valid && !bus.insr[7];
    accept = (state == IDLE || state == WB) && take;
    nxt = (state == IDLE || state == WB) ? (take ? RDA : IDLE) :
          (state == RDA) ? RDB :
          (state == RDB) ? EXEC :
          bus.alu_done ? WB : EXEC;
    bus.insr_ready = state == IDLE || state == WB;
    bus.rf_re = state == RDA || state == RDB;
    bus.rf_we = state == WB;
    bus.alu_start = state == EXEC && first;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      first <= 1'b0;
      op <= '0;
      dest <= '0;
      src_b_r <= '0;
      raddr <= '0;
      waddr <= '0;
      opa <= '0;
      opb <= '0;
      res <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      first <= state == RDB;
      if (accept) begin
        op <= bus.insr[3:0];
        dest <= dst;
        src_b_r <= src_b;
        raddr <= src_a;
      end
      if (state == RDA) raddr <= src_b_r;
      if (state == RDB) opa <= bus.rf_rdata;
      if (first) opb <= bus.rf_rdata;
      if (state == EXEC && bus.alu_done) begin
        res <= bus.alu_result;
        waddr <= dest;
      end
      if (state == WB) cnt <= cnt + 1'b1;
    end
  end
  // operand B arrives from the RF during the first EXEC cycle, so it is forwarded until it is captured
  assign bus.alu_b = first ? bus.rf_rdata : opb;
  assign bus.alu_a = opa;
  assign bus.alu_op = op;
  assign bus.rf_raddr = raddr;
  assign bus.rf_waddr = waddr;
  assign bus.rf_wdata = res;
  assign bus.retired = cnt;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors against a register-file and ALU model, with a narrow counter to reach the wrap
module tb_alu_sequencer;
  localparam int DW = 8;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_sequencer_if #(.DW(DW), .CNT_W(CW)) bus ();
  alu_sequencer #(.DW(DW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int dly = 0;
  int cnt = 0;
  int start_cnt = 0;
  int chg = 0;
  int acc = 0;
  int a1, a2;
  logic pend = 1'b0;
  logic in_exec = 1'b0;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] sa, sb;
  logic [3:0] so;
  int rd_q[$];
  int we_a[$];
  int we_d[$];
  int we_c[$];
  always @(posedge clk) cyc <= cyc + 1;
  // ALU: result = a + b + op, done after dly extra cycles
  assign bus.alu_result = bus.alu_a + bus.alu_b + {4'h0, bus.alu_op};
  assign bus.alu_done = (bus.alu_start && dly == 0) || (pend && cnt == 0);
  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else if (bus.alu_start && dly != 0) begin
      pend <= 1'b1;
      cnt <= dly - 1;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= (i == 1) ? 8'h11 : (i == 2) ? 8'h22 : (i == 3) ? 8'h40 : 8'h00;
      bus.rf_rdata <= '0;
    end else begin
      if (bus.rf_re) bus.rf_rdata <= mem[bus.rf_raddr];
      if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
    end
  end
  always @(negedge clk) begin
    if (rst) in_exec <= 1'b0;
    else begin
      if (bus.rf_re) rd_q.push_back(int'(bus.rf_raddr));
      if (bus.rf_we) begin
        we_a.push_back(int'(bus.rf_waddr));
        we_d.push_back(int'(bus.rf_wdata));
        we_c.push_back(cyc);
        in_exec <= 1'b0;
      end
      if (bus.alu_start) begin
        start_cnt <= start_cnt + 1;
        sa <= bus.alu_a;
        sb <= bus.alu_b;
        so <= bus.alu_op;
        in_exec <= 1'b1;
      end else if (in_exec && (bus.alu_a != sa || bus.alu_b != sb || bus.alu_op != so))
        chg <= chg + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.insr = b;
    bus.insr_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.insr_ready; i++) @(negedge clk);
    check("accept_ready", bus.insr_ready, 1);
    acc = cyc;
  endtask
  task automatic idle();
    @(negedge clk);
    bus.insr_valid = 1'b0;
    bus.insr = 8'h00;
  endtask
  task automatic wait_we(input int n);
    for (int i = 0; i < 60 && we_c.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    check("we_count", we_c.size(), n);
    @(negedge clk);
    #1;
  endtask
  initial begin
    bus.insr = 8'h00;
    bus.insr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.insr_ready, 1);
    check("rst_retired", bus.retired, 0);
    check("rst_strobes", {bus.rf_re, bus.rf_we, bus.alu_start}, 0);
    check("rst_regs", {bus.alu_a, bus.alu_b, bus.alu_op, bus.rf_waddr, bus.rf_raddr}, 0);
    check("rst_wdata", bus.rf_wdata, 0);
    // CREG0 op5: A = X + Y + 5
    send(8'h05);
    idle();
    wait_we(1);
    check("t1_rda", rd_q[0], 1);
    check("t1_rdb", rd_q[1], 2);
    check("t1_starts", start_cnt, 1);
    check("t1_alu_a", sa, 8'h11);
    check("t1_alu_b", sb, 8'h22);
    check("t1_alu_op", so, 5);
    check("t1_waddr", we_a[0], 0);
    check("t1_wdata", we_d[0], 8'h38);
    check("t1_latency", we_c[0] - acc, 4);
    check("t1_retired", bus.retired, 1);
    // CREG4 op10: D = A + D + 10
    send(8'h4A);
    idle();
    wait_we(2);
    check("t2_rda", rd_q[2], 0);
    check("t2_rdb", rd_q[3], 3);
    check("t2_waddr", we_a[1], 3);
    check("t2_wdata", we_d[1], 8'h82);
    check("t2_retired", bus.retired, 2);
    // ce_n set: consumed, nothing happens
    send(8'h85);
    idle();
    repeat (6) @(negedge clk);
    check("t3_reads", rd_q.size(), 4);
    check("t3_starts", start_cnt, 2);
    check("t3_writes", we_c.size(), 2);
    check("t3_retired", bus.retired, 2);
    check("t3_busy", bus.busy, 0);
    // slow ALU: CREG1 op2, A = X + A + 2
    dly = 3;
    send(8'h12);
    idle();
    wait_we(3);
    dly = 0;
    check("t4_rda", rd_q[4], 1);
    check("t4_rdb", rd_q[5], 0);
    check("t4_starts", start_cnt, 3);
    check("t4_stable", chg, 0);
    check("t4_latency", we_c[2] - acc, 7);
    check("t4_wdata", we_d[2], 8'h4B);
    check("t4_retired", bus.retired, 3);
    // back-to-back: second byte accepted in WB of the first
    send(8'h01);
    a1 = acc;
    send(8'h72);
    a2 = acc;
    idle();
    wait_we(5);
    check("t5_accept_gap", a2 - a1, 4);
    check("t5_first_lat", we_c[3] - a1, 4);
    check("t5_we_gap", we_c[4] - we_c[3], 4);
    check("t5_wdata0", we_d[3], 8'h34);
    check("t5_waddr0", we_a[3], 0);
    check("t5_rd_d", {rd_q[8][3:0], rd_q[9][3:0]}, 8'h33);
    check("t5_wdata1", we_d[4], 8'h06);
    check("t5_waddr1", we_a[4], 3);
    check("t5_retired", bus.retired, 5);
    // asynchronous reset in the middle of EXEC
    dly = 5;
    send(8'h05);
    idle();
    for (int i = 0; i < 20 && start_cnt < 6; i++) begin
      @(negedge clk);
      #1;
    end
    check("t6_started", start_cnt, 6);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_retired", bus.retired, 0);
    check("t6_regs", {bus.alu_a, bus.alu_b, bus.rf_wdata}, 0);
    repeat (3) @(negedge clk);
    check("t6_no_write", we_c.size(), 5);
    rst = 1'b0;
    dly = 0;
    send(8'h05);
    idle();
    wait_we(6);
    check("t6_after_wdata", we_d[5], 8'h38);
    check("t6_after_retired", bus.retired, 1);
    // counter wrap
    for (int i = 0; i < 14; i++) begin
      send(8'h00);
      idle();
      wait_we(7 + i);
    end
    check("t7_full", bus.retired, 15);
    check("t7_wdata", we_d[19], 8'h33);
    send(8'h00);
    idle();
    wait_we(21);
    check("t7_wrap", bus.retired, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
